// File: rtl/cpu_step_ctrl.sv
// Purpose: run/step/breakpoint controller for the RV32 core, built around a debounced btn0 press.
// Latency: btn_press appears DEBOUNCE_CYCLES+3 cycles after a clean btn0 edge; the FSM reacts on the following edge.
// Backpressure: none. cpu_en is the only stall source, and it freezes PC and every pipeline register together.
module cpu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn0,
    input  logic             run_mode,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      PC,
    output logic             cpu_en,
    output logic             halted,
    output logic             bp_hit,
    output logic             btn_press,
    output logic [CNT_W-1:0] cycle_count
);

    // The debounce counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int              DEB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_HALT   = 3'd0,
        S_STEP   = 3'd1,
        S_RUN    = 3'd2,
        S_BREAK  = 3'd3,
        S_RESUME = 3'd4
    } ctrlState_t;

    logic             btnMeta;
    logic             btnS;
    logic [1:0]       syncVld;
    logic             btnArmed;
    logic [DEB_W-1:0] debCnt;
    logic             debLevel;
    logic             debLevelQ;
    logic             bpMatch;
    logic             bpHitNext;
    ctrlState_t       state;
    ctrlState_t       stateNext;

    // Two-flop synchroniser for the asynchronous push-button. syncVld records when
    // btnS holds a real sample rather than the reset value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btnMeta <= 1'b0;
            btnS    <= 1'b0;
            syncVld <= 2'b00;
        end else begin
            btnMeta <= btn0;
            btnS    <= btnMeta;
            syncVld <= {syncVld[0], 1'b1};
        end
    end

    // A button held through reset must not count as a press. Presses are only armed
    // once a genuine low level has come through the synchroniser.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btnArmed <= 1'b0;
        end else begin
            btnArmed <= btnArmed | (syncVld[1] & ~btnS);
        end
    end

    // Debouncer. A new level is accepted only after DEBOUNCE_CYCLES consecutive
    // samples that all differ from the current level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            debCnt   <= '0;
            debLevel <= 1'b0;
        end else if (btnS == debLevel) begin
            debCnt   <= '0;
        end else if (debCnt == DEB_LAST) begin
            debLevel <= btnS;
            debCnt   <= '0;
        end else begin
            debCnt   <= debCnt + DEB_W'(1);
        end
    end

    // Registered one-cycle pulse on each rising debounced edge. Releases produce nothing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            debLevelQ <= 1'b0;
            btn_press <= 1'b0;
        end else begin
            debLevelQ <= debLevel;
            btn_press <= debLevel & ~debLevelQ & btnArmed;
        end
    end

    // The breakpoint compare is consulted only in RUN. RESUME ignores it so execution can step past bp_addr.
    assign bpMatch = bp_en & (PC == bp_addr);

    // State register and sticky breakpoint flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_HALT;
            bp_hit <= 1'b0;
        end else begin
            state  <= stateNext;
            bp_hit <= bpHitNext;
        end
    end

    // Next-state and clock-enable decode. cpu_en is high only in STEP, RESUME, or an
    // unmatched RUN cycle with no press, so it stays low in HALT and BREAK.
    always_comb begin
        stateNext = state;
        bpHitNext = bp_hit;
        cpu_en    = 1'b0;
        case (state)
            S_HALT: begin
                if (btn_press) begin
                    bpHitNext = 1'b0;
                    stateNext = run_mode ? S_RUN : S_STEP;
                end
            end
            S_STEP: begin
                // Exactly one enabled cycle. A press arriving now is dropped.
                cpu_en    = 1'b1;
                stateNext = S_HALT;
            end
            S_RUN: begin
                // A press wins over a simultaneous breakpoint match.
                if (btn_press) begin
                    stateNext = S_HALT;
                end else if (bpMatch) begin
                    stateNext = S_BREAK;
                    bpHitNext = 1'b1;
                end else begin
                    cpu_en    = 1'b1;
                end
            end
            S_BREAK: begin
                if (btn_press) begin
                    bpHitNext = 1'b0;
                    stateNext = S_RESUME;
                end
            end
            S_RESUME: begin
                cpu_en    = 1'b1;
                stateNext = run_mode ? S_RUN : S_HALT;
            end
            default: begin
                stateNext = S_HALT;
            end
        endcase
    end

    // halted is decoded from the state register alone, never from the PC compare.
    assign halted = (state == S_HALT) || (state == S_BREAK);

    // Count of enabled cycles. It wraps silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count <= '0;
        end else if (cpu_en) begin
            cycle_count <= cycle_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Purpose: bench for cpu_step_ctrl with DEBOUNCE_CYCLES=4. A second instance uses CNT_W=4 to exercise counter wrap.
// Latency: the reference model predicts every output for each cycle. Checks are made just after the falling edge.
// Backpressure: not applicable. The bench plays the core and advances PC by 4 on each enabled cycle.
module tb_cpu_step_ctrl;

    localparam int DEB = 4;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        btn0     = 1'b0;
    logic        run_mode = 1'b0;
    logic        bp_en    = 1'b0;
    logic [31:0] bp_addr  = '0;
    logic [31:0] PC       = '0;

    logic        cpuEn, halted, bpHit, btnPress;
    logic [31:0] cycleCount;
    logic        cpuEnW, haltedW, bpHitW, btnPressW;
    logic [3:0]  cycleCountW;

    always #5 clk = ~clk;

    cpu_step_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .btn0(btn0), .run_mode(run_mode), .bp_en(bp_en),
        .bp_addr(bp_addr), .PC(PC), .cpu_en(cpuEn), .halted(halted), .bp_hit(bpHit),
        .btn_press(btnPress), .cycle_count(cycleCount)
    );

    cpu_step_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(4)) dutW (
        .clk(clk), .reset(reset), .btn0(btn0), .run_mode(run_mode), .bp_en(bp_en),
        .bp_addr(bp_addr), .PC(PC), .cpu_en(cpuEnW), .halted(haltedW), .bp_hit(bpHitW),
        .btn_press(btnPressW), .cycle_count(cycleCountW)
    );

    int nChecks = 0;
    int nFails  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model, written at the level of the behavioural rules rather than the RTL structure.
    localparam int M_HALT = 0, M_STEP = 1, M_RUN = 2, M_BREAK = 3, M_RESUME = 4;
    int          mMode;
    bit          mS1, mS2, mArmed, mLevel, mRose, mPress, mBpHit;
    int          mRunLen, mSamples;
    logic [31:0] mCount, mPC;

    function automatic bit mEn();
        bit match;
        match = bp_en && (PC == bp_addr);
        case (mMode)
            M_STEP, M_RESUME: return 1'b1;
            M_RUN:            return !(mPress || match);
            default:          return 1'b0;
        endcase
    endfunction

    task automatic modelReset();
        mMode = M_HALT; mS1 = 0; mS2 = 0; mArmed = 0; mLevel = 0; mRose = 0;
        mPress = 0; mBpHit = 0; mRunLen = 0; mSamples = 0; mCount = '0; mPC = '0;
    endtask

    task automatic modelStep();
        bit en, btnS, newPress;
        en = mEn();
        case (mMode)
            M_HALT:  if (mPress) begin mBpHit = 0; mMode = run_mode ? M_RUN : M_STEP; end
            M_STEP:  mMode = M_HALT;
            M_RUN:   if (mPress) mMode = M_HALT;
                     else if (bp_en && PC == bp_addr) begin mMode = M_BREAK; mBpHit = 1; end
            M_BREAK: if (mPress) begin mMode = M_RESUME; mBpHit = 0; end
            default: mMode = run_mode ? M_RUN : M_HALT;
        endcase
        if (en) begin
            mCount = mCount + 32'd1;
            mPC    = mPC + 32'd4;
        end
        // Button path: a 2-sample delay line, then a run of DEB differing samples to flip the level.
        newPress = mRose && mArmed;
        btnS     = mS2;
        if (mSamples >= 2 && !btnS) mArmed = 1;
        mRose = 0;
        if (btnS != mLevel) begin
            mRunLen++;
            if (mRunLen == DEB) begin
                mLevel  = btnS;
                mRunLen = 0;
                mRose   = btnS;
            end
        end else begin
            mRunLen = 0;
        end
        mS2 = mS1;
        mS1 = btn0;
        if (mSamples < 2) mSamples++;
        mPress = newPress;
    endtask

    bit          btnStim = 0, modeStim = 0, bpEnStim = 0, rstLevel = 0;
    logic [31:0] bpAddrStim = '0;
    bit          obsPress;
    int          pressSeen = 0;

    // One clock cycle: drive on the falling edge, check 1 ns later, advance the model on the rising edge.
    task automatic tick();
        @(negedge clk);
        reset    = rstLevel;
        btn0     = btnStim;
        run_mode = modeStim;
        bp_en    = bpEnStim;
        bp_addr  = bpAddrStim;
        PC       = mPC;
        #1;
        chk("cpu_en",      32'(cpuEn),       32'(mEn()));
        chk("halted",      32'(halted),      32'(mMode == M_HALT || mMode == M_BREAK));
        chk("bp_hit",      32'(bpHit),       32'(mBpHit));
        chk("btn_press",   32'(btnPress),    32'(mPress));
        chk("cycle_count", cycleCount,       mCount);
        chk("count_w4",    32'(cycleCountW), mCount & 32'hF);
        obsPress = btnPress;
        if (btnPress) pressSeen++;
        @(posedge clk);
        if (reset) modelStep();
        #1;
    endtask

    // Assert reset mid-cycle and confirm the outputs drop immediately, before any clock edge.
    task automatic doReset(input int hold);
        @(negedge clk);
        #2;
        reset    = 1'b0;
        rstLevel = 1'b0;
        modelReset();
        #1;
        chk("rst_cpu_en",    32'(cpuEn),    32'd0);
        chk("rst_halted",    32'(halted),   32'd1);
        chk("rst_bp_hit",    32'(bpHit),    32'd0);
        chk("rst_btn_press", 32'(btnPress), 32'd0);
        chk("rst_count",     cycleCount,    32'd0);
        repeat (hold) tick();
        rstLevel = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, nChecks=%0d", nChecks);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n, seg;
        bit hit;

        modelReset();
        doReset(3);

        // Single step: measure press latency, then confirm exactly one enabled cycle.
        repeat (6) tick();
        modeStim = 0;
        btnStim  = 1;
        lat      = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (obsPress && lat < 0) lat = i - 1;
        end
        chk("press_latency", 32'(lat), 32'(DEB + 3));
        btnStim = 0;
        repeat (10) tick();
        chk("step_count",  cycleCount,  32'd1);
        chk("step_halted", 32'(halted), 32'd1);

        // Pulses shorter than the debounce window are ignored.
        pressSeen = 0;
        for (int w = 1; w <= 3; w++) begin
            btnStim = 1;
            repeat (w) tick();
            btnStim = 0;
            repeat (8) tick();
        end
        chk("glitch_press", 32'(pressSeen), 32'd0);
        chk("glitch_count", cycleCount,     32'd1);

        // Free run into the breakpoint at 0x20, then resume past it.
        doReset(2);
        repeat (4) tick();
        modeStim   = 1;
        bpEnStim   = 1;
        bpAddrStim = 32'h20;
        btnStim    = 1;
        n          = 0;
        while (mMode != M_BREAK && n < 80) begin
            tick();
            n++;
            if (n == 8) btnStim = 0;
        end
        btnStim = 0;
        chk("bp_halted", 32'(halted), 32'd1);
        chk("bp_hit",    32'(bpHit),  32'd1);
        chk("bp_count",  cycleCount,  32'd8);
        repeat (3) tick();
        btnStim = 1;
        repeat (8) tick();
        btnStim = 0;
        repeat (30) tick();
        chk("resume_bp_hit",  32'(bpHit),       32'd0);
        chk("resume_running", 32'(halted),      32'd0);
        chk("wrap_w4",        32'(cycleCountW), 32'(cycleCount[3:0]));

        // A press landing in the same cycle as a breakpoint match wins.
        btnStim = 1;
        hit     = 0;
        for (int i = 0; i < 14; i++) begin
            if (mPress && mMode == M_RUN) begin
                bpAddrStim = mPC;
                hit        = 1;
            end
            tick();
            if (hit) break;
        end
        chk("coinc_halted", 32'(halted), 32'd1);
        chk("coinc_bp_hit", 32'(bpHit),  32'd0);
        btnStim = 0;
        repeat (10) tick();

        // Reset while running and mid-debounce, with btn0 held high through and after reset.
        bpEnStim = 0;
        modeStim = 1;
        btnStim  = 1;
        repeat (8) tick();
        btnStim = 0;
        repeat (6) tick();
        btnStim = 1;
        repeat (3) tick();
        doReset(3);
        pressSeen = 0;
        repeat (20) tick();
        chk("held_press", 32'(pressSeen), 32'd0);
        chk("held_count", cycleCount,     32'd0);
        btnStim = 0;
        repeat (10) tick();
        btnStim = 1;
        repeat (10) tick();
        chk("rearm_press", 32'(pressSeen), 32'd1);
        btnStim = 0;
        repeat (10) tick();

        // Random phase: random button segments, mode and breakpoint changes, and occasional resets.
        seg = 0;
        repeat (3000) begin
            if (seg <= 0) begin
                btnStim = ~btnStim;
                seg     = int'($urandom_range(1, 14));
                if ($urandom_range(0, 3) == 0) modeStim = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) bpEnStim = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 19) == 0) bpAddrStim = mPC + 32'(4 * $urandom_range(0, 8));
            if ($urandom_range(0, 599) == 0) doReset(int'($urandom_range(1, 4)));
            tick();
            seg--;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/cpu_step_ctrl.md
Name: cpu_step_ctrl

Overview:
- Run/step/breakpoint controller for the pipelined RV32 core.
- Turns the raw btn0 push-button into a debounced press, then drives a single clock-enable (cpu_en) to the PC register and every pipeline stage register, including the writeback register.
- Supports free-run, single-step, and a PC-match breakpoint, so the 7-segment display can show PC/InstrF frozen at a chosen point.
- Counts enabled cycles for on-board inspection.

Parameters:
- DEBOUNCE_CYCLES, 16, number of consecutive identical synchronised btn0 samples required to accept a new level (boards use ~1_000_000).
- CNT_W, 32, width of cycle_count.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- btn0  input  1  raw push-button, asynchronous to clk, active-high
- run_mode  input  1  1 = press starts free-run; 0 = press executes one step
- bp_en  input  1  breakpoint enable
- bp_addr  input  32  breakpoint PC value
- PC  input  32  current fetch PC from the core
- cpu_en  output  1  clock enable to PC and all pipeline registers
- halted  output  1  1 in HALT or BREAK
- bp_hit  output  1  sticky; set on breakpoint entry, cleared on next accepted press
- btn_press  output  1  one-cycle pulse per accepted press (debug visibility)
- cycle_count  output  CNT_W  number of cycles with cpu_en=1

Behaviour:
- Reset (reset=0, async):
  - state=HALT; cpu_en=0, halted=1, bp_hit=0, btn_press=0, cycle_count=0.
  - Sync flops, debounce counter and debounced level all cleared to 0.
  - Reset mid-run takes effect immediately; no step completes.
- Synchroniser: btn0 passes through 2 flops to btn_s.
- Debouncer:
  - counter clears whenever btn_s == deb_level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, deb_level <= btn_s and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never change deb_level.
- btn_press: registered pulse, 1 cycle after deb_level rises 0->1. Releases generate nothing.
- Latency: a clean btn0 rising edge held steady produces btn_press exactly DEBOUNCE_CYCLES+3 cycles later.
- FSM states: HALT, STEP, RUN, BREAK, RESUME.
  - HALT: cpu_en=0.
    - btn_press with run_mode=1 -> RUN.
    - btn_press with run_mode=0 -> STEP.
    - run_mode is sampled only in the press cycle.
  - STEP: cpu_en=1 for exactly one cycle, then -> HALT unconditionally. Breakpoint is ignored in STEP.
  - RUN: cpu_en = ~(bp_en & (PC==bp_addr)) (combinational).
    - btn_press -> HALT with cpu_en=0 that cycle. Press has priority over a simultaneous breakpoint match; bp_hit is not set.
    - else match -> BREAK, bp_hit<=1. The PC stays at bp_addr, so the display shows it.
  - BREAK: cpu_en=0.
    - btn_press -> RESUME, bp_hit<=0.
  - RESUME: cpu_en=1 for one cycle with the breakpoint compare masked, so execution moves past bp_addr.
    - Then -> RUN if run_mode=1, else -> HALT.
    - A press during RESUME is ignored.
- btn_press arriving in STEP is ignored; no queueing.
- bp_hit also clears on any accepted press from HALT.
- halted is registered-equivalent: it is decoded from state only, never from the compare.
- cycle_count increments by 1 on every clk edge where cpu_en=1. It wraps modulo 2^CNT_W (0xFFFFFFFF -> 0) with no flag.
- bp_en toggling while in BREAK has no effect until the next RUN cycle.
- No output may glitch high in HALT or BREAK.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then btn0 held 1 from cycle 10, run_mode=0 -> btn_press at cycle 17. cpu_en=1 only in cycle 18. cycle_count=1, halted=1 afterward.
- btn0 pulses of 1, 2 and 3 cycles -> no btn_press, cpu_en stays 0, cycle_count=0.
- run_mode=1, bp_en=1, bp_addr=0x20; PC advances by 4 each enabled cycle from 0:
  - cpu_en drops in the cycle PC==0x20; halted=1, bp_hit=1, cycle_count=8.
  - Next press -> RESUME: one enabled cycle, PC becomes 0x24, bp_hit=0; run continues.
- In RUN, press and PC==bp_addr occur in the same cycle -> state HALT, bp_hit=0, cpu_en=0 that cycle.
- Assert reset during RUN, mid-debounce with btn0 high -> all outputs at reset values immediately. No press is produced until btn0 is seen 0 then 1 again after reset release.
- Preload cycle_count scenario: run 2^CNT_W cycles with CNT_W=4 override -> count wraps 15->0 and run continues uninterrupted.
